rtc_access_scheduler: RTL and testbench
=======================================

// Module: rtc_access_scheduler
// PURPOSE
//  Sequences the single RTC bus engine shared by user write-back and periodic time refresh.
//  Requester 1: the user-control write-back path (one addr/data write per request).
//  Requester 2: an internal refresh timer that reads NREAD consecutive RTC registers for display.
//  Writes have priority; bus hangs are caught by a watchdog.
// PARAMETERS
//  REFRESH_TICKS  1000000  clock cycles between refresh bursts (counter 24 bits)
//  READ_BASE      8'h21    RTC address of refresh index 0
//  NREAD          6        registers read per burst (1..16)
//  TIMEOUT        255      max cycles waiting for bus_done (8-bit counter)
// PORTS
//  CLK         in   1  system clock, all logic on rising edge
//  reset       in   1  synchronous, active-low reset
//  hold        in   1  1 = user editing: suppress refresh bursts, writes still served
//  wr_req      in   1  write request, held with wr_addr/wr_data stable until wr_ack
//  wr_addr     in   8  RTC register address for write
//  wr_data     in   8  data for write
//  wr_ack      out  1  1-cycle pulse: write finished (ok or error)
//  wr_err      out  1  1-cycle pulse with wr_ack when write timed out
//  bus_start   out  1  1-cycle pulse: launch transaction on bus engine
//  bus_rw      out  1  1 = write, 0 = read; stable from bus_start until done/timeout
//  bus_addr    out  8  transaction address, stable as bus_rw
//  bus_wdata   out  8  write data, stable as bus_rw
//  bus_rdata   in   8  read data, valid in bus_done cycle
//  bus_done    in   1  1-cycle pulse from bus engine: transaction complete
//  rd_valid    out  1  1-cycle pulse: rd_data/rd_index hold a fresh refresh read
//  rd_index    out  4  refresh index 0..NREAD-1 (address = READ_BASE+index)
//  rd_data     out  8  captured bus_rdata
//  frame_done  out  1  1-cycle pulse after index NREAD-1 delivered
//  bus_err     out  1  1-cycle pulse on any watchdog timeout
//  busy        out  1  1 whenever state != IDLE
// BEHAVIOUR
//  Reset (reset==0 at edge): state IDLE; all outputs 0; refresh counter, index, watchdog, pend = 0.
//  All outputs registered. Reset mid-transaction abandons it; late bus_done afterwards ignored.
//  Refresh timer free-runs regardless of hold; at count REFRESH_TICKS-1 wraps to 0, sets pend.
//   Ticks while pend already set coalesce (no queueing).
//  States: IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT.
//  IDLE: wr_req -> latch addr/data, WR_ISSUE; else pend && !hold -> index=0, clear pend, RD_ISSUE.
//   Same-cycle wr_req and tick: write first, pend kept. pend && hold: pend stays set.
//  *_ISSUE: bus_start=1 for exactly one cycle, watchdog=0, -> *_WAIT. Edge seeing wr_req -> bus_start high next cycle.
//  WR_WAIT: bus_done -> wr_ack=1 next cycle; return to RD_ISSUE(next index) if burst suspended, else IDLE.
//  RD_WAIT: bus_done -> rd_data=bus_rdata, rd_index=index, rd_valid=1 next cycle; then:
//   index==NREAD-1 -> frame_done=1 with rd_valid, IDLE.
//   else hold==1 -> burst abandoned (no frame_done), IDLE.
//   else wr_req -> suspend burst (index+1 saved), WR_ISSUE.
//   else index+1, RD_ISSUE.
//  Writes never preempt an in-flight read; they are inserted only between reads.
//  Watchdog: counts in *_WAIT; reaching TIMEOUT without bus_done -> bus_err=1;
//   write: wr_ack=wr_err=1, IDLE (suspended burst also dropped); read: no rd_valid, burst dropped, IDLE.
//   bus_done in the timeout cycle wins (normal completion, no error).
//  bus_done outside *_WAIT ignored. Requester must drop wr_req the cycle after wr_ack,
//   else it is taken as a new request.
// TESTING
//  1. reset low 3 cycles then high -> all outputs 0, busy 0; no bus_start until first tick.
//  2. Idle, wr_req addr 8'h22 data 8'h45, bus_done 4 cycles after start -> one bus_start rw=1 addr 22 wdata 45, wr_ack 1 cycle after done.
//  3. REFRESH_TICKS=20, NREAD=6, engine returns addr as data -> 6 rd_valid, index 0..5, data 21..26, frame_done with last.
//  4. wr_req raised during read of index 2 -> index 2 completes, write issued, burst resumes at index 3, frame_done still produced.
//  5. hold=1 before tick -> no read starts, pend held; hold=0 -> burst starts next cycle; hold=1 mid-burst -> stops after current read, no frame_done.
//  6. TIMEOUT=8, bus_done never -> bus_err after 8 WAIT cycles, wr_ack+wr_err for a write; done on cycle 8 -> no error.

Source files
------------

// File: rtl/rtc_access_scheduler.sv
// Arbitrates the single RTC bus engine between user write-back requests and
// periodic refresh bursts of NREAD consecutive register reads, with a bus watchdog.
module rtc_access_scheduler #(
  parameter int unsigned REFRESH_TICKS = 1000000,
  parameter logic [7:0]  READ_BASE     = 8'h21,
  parameter int unsigned NREAD         = 6,
  parameter int unsigned TIMEOUT       = 255
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       hold,
  input  logic       wr_req,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  output logic       wr_err,
  output logic       bus_start,
  output logic       bus_rw,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_wdata,
  input  logic [7:0] bus_rdata,
  input  logic       bus_done,
  output logic       rd_valid,
  output logic [3:0] rd_index,
  output logic [7:0] rd_data,
  output logic       frame_done,
  output logic       bus_err,
  output logic       busy
);

  localparam int unsigned CNT_W = 24;
  localparam int unsigned IDX_W = 4;
  localparam int unsigned WD_W  = 8;
  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 8;

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(REFRESH_TICKS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NREAD - 1);
  localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_ISSUE = 3'd1,
    WR_WAIT  = 3'd2,
    RD_ISSUE = 3'd3,
    RD_WAIT  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic              pend_q, pend_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              susp_q, susp_d;
  logic [WD_W-1:0]   wd_q, wd_d;

  logic              wr_ack_q, wr_ack_d;
  logic              wr_err_q, wr_err_d;
  logic              bus_start_q, bus_start_d;
  logic              bus_rw_q, bus_rw_d;
  logic [AW-1:0]     bus_addr_q, bus_addr_d;
  logic [DW-1:0]     bus_wdata_q, bus_wdata_d;
  logic              rd_valid_q, rd_valid_d;
  logic [IDX_W-1:0]  rd_index_q, rd_index_d;
  logic [DW-1:0]     rd_data_q, rd_data_d;
  logic              frame_done_q, frame_done_d;
  logic              bus_err_q, bus_err_d;
  logic              busy_q, busy_d;

  logic              tick_c;
  logic              wr_take_c;
  logic              consume_c;
  logic [IDX_W-1:0]  idx_inc_c;

  // Next-state, timer and output computation
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    susp_d       = susp_q;
    wd_d         = wd_q;
    consume_c    = 1'b0;
    wr_ack_d     = 1'b0;
    wr_err_d     = 1'b0;
    bus_start_d  = 1'b0;
    rd_valid_d   = 1'b0;
    frame_done_d = 1'b0;
    bus_err_d    = 1'b0;
    bus_rw_d     = bus_rw_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    rd_index_d   = rd_index_q;
    rd_data_d    = rd_data_q;

    tick_c     = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick_c ? '0 : tick_cnt_q + CNT_W'(1);
    // A request still high during its own ack cycle is the old one
    wr_take_c  = wr_req && !wr_ack_q;
    idx_inc_c  = idx_q + IDX_W'(1);

    case (state_q)
      IDLE: begin
        if (wr_take_c) begin
          state_d     = WR_ISSUE;
          bus_start_d = 1'b1;
          bus_rw_d    = 1'b1;
          bus_addr_d  = wr_addr;
          bus_wdata_d = wr_data;
        end else if (pend_q && !hold) begin
          state_d     = RD_ISSUE;
          idx_d       = '0;
          susp_d      = 1'b0;
          consume_c   = 1'b1;
          bus_start_d = 1'b1;
          bus_rw_d    = 1'b0;
          bus_addr_d  = READ_BASE;
          bus_wdata_d = '0;
        end
      end

      WR_ISSUE: begin
        state_d = WR_WAIT;
        wd_d    = '0;
      end

      RD_ISSUE: begin
        state_d = RD_WAIT;
        wd_d    = '0;
      end

      WR_WAIT: begin
        if (bus_done) begin
          wr_ack_d = 1'b1;
          if (susp_q) begin
            state_d     = RD_ISSUE;
            susp_d      = 1'b0;
            bus_start_d = 1'b1;
            bus_rw_d    = 1'b0;
            bus_addr_d  = READ_BASE + {4'h0, idx_q};
            bus_wdata_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (wd_q == WD_LAST) begin
          state_d   = IDLE;
          wr_ack_d  = 1'b1;
          wr_err_d  = 1'b1;
          bus_err_d = 1'b1;
          susp_d    = 1'b0;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end

      RD_WAIT: begin
        if (bus_done) begin
          rd_valid_d = 1'b1;
          rd_data_d  = bus_rdata;
          rd_index_d = idx_q;
          if (idx_q == IDX_LAST) begin
            state_d      = IDLE;
            frame_done_d = 1'b1;
          end else if (hold) begin
            state_d = IDLE;
          end else if (wr_take_c) begin
            // Park the burst at the next index while the write goes out
            state_d     = WR_ISSUE;
            idx_d       = idx_inc_c;
            susp_d      = 1'b1;
            bus_start_d = 1'b1;
            bus_rw_d    = 1'b1;
            bus_addr_d  = wr_addr;
            bus_wdata_d = wr_data;
          end else begin
            state_d     = RD_ISSUE;
            idx_d       = idx_inc_c;
            bus_start_d = 1'b1;
            bus_rw_d    = 1'b0;
            bus_addr_d  = READ_BASE + {4'h0, idx_inc_c};
            bus_wdata_d = '0;
          end
        end else if (wd_q == WD_LAST) begin
          state_d   = IDLE;
          bus_err_d = 1'b1;
          susp_d    = 1'b0;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    pend_d = tick_c | (pend_q & ~consume_c);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q      <= IDLE;
      tick_cnt_q   <= '0;
      pend_q       <= 1'b0;
      idx_q        <= '0;
      susp_q       <= 1'b0;
      wd_q         <= '0;
      wr_ack_q     <= 1'b0;
      wr_err_q     <= 1'b0;
      bus_start_q  <= 1'b0;
      bus_rw_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      rd_valid_q   <= 1'b0;
      rd_index_q   <= '0;
      rd_data_q    <= '0;
      frame_done_q <= 1'b0;
      bus_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      pend_q       <= pend_d;
      idx_q        <= idx_d;
      susp_q       <= susp_d;
      wd_q         <= wd_d;
      wr_ack_q     <= wr_ack_d;
      wr_err_q     <= wr_err_d;
      bus_start_q  <= bus_start_d;
      bus_rw_q     <= bus_rw_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      rd_valid_q   <= rd_valid_d;
      rd_index_q   <= rd_index_d;
      rd_data_q    <= rd_data_d;
      frame_done_q <= frame_done_d;
      bus_err_q    <= bus_err_d;
      busy_q       <= busy_d;
    end
  end

  assign wr_ack     = wr_ack_q;
  assign wr_err     = wr_err_q;
  assign bus_start  = bus_start_q;
  assign bus_rw     = bus_rw_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;
  assign rd_valid   = rd_valid_q;
  assign rd_index   = rd_index_q;
  assign rd_data    = rd_data_q;
  assign frame_done = frame_done_q;
  assign bus_err    = bus_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_rtc_access_scheduler.sv
// Bench for rtc_access_scheduler: directed scenarios plus random traffic, every
// cycle compared against a transaction-level model of the scheduler.
module tb_rtc_access_scheduler;

  localparam int unsigned TICKS = 20;
  localparam int unsigned NRD   = 6;
  localparam int unsigned TMO   = 8;
  localparam logic [7:0]  BASE  = 8'h21;

  logic       CLK = 1'b0;
  logic       reset, hold, wr_req, bus_done;
  logic [7:0] wr_addr, wr_data, bus_rdata;
  logic       wr_ack, wr_err, bus_start, bus_rw, rd_valid, frame_done, bus_err, busy;
  logic [7:0] bus_addr, bus_wdata, rd_data;
  logic [3:0] rd_index;

  always #5 CLK = ~CLK;

  rtc_access_scheduler #(
    .REFRESH_TICKS(TICKS), .READ_BASE(BASE), .NREAD(NRD), .TIMEOUT(TMO)
  ) dut (
    .CLK(CLK), .reset(reset), .hold(hold), .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ack(wr_ack), .wr_err(wr_err), .bus_start(bus_start),
    .bus_rw(bus_rw), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_done(bus_done), .rd_valid(rd_valid), .rd_index(rd_index), .rd_data(rd_data),
    .frame_done(frame_done), .bus_err(bus_err), .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;

  // Reference model: what the scheduler is doing, in transaction terms
  int  m_cnt, m_idx, m_wait;
  bit  m_pend, m_active, m_issued, m_is_wr, m_parked;
  logic       e_wr_ack, e_wr_err, e_bus_start, e_bus_rw, e_rd_valid, e_frame_done, e_bus_err, e_busy;
  logic [7:0] e_bus_addr, e_bus_wdata, e_rd_data;
  logic [3:0] e_rd_index;

  // Bus engine and requester stimulus state
  int         eng_cnt = 0;
  int         eng_delay = 2;
  bit         eng_rand = 1'b0;
  bit         spurious_en = 1'b0;
  bit         late_drop_en = 1'b0;
  bit         drop_pending = 1'b0;
  logic [7:0] eng_data = 8'h00;

  // Event counters for directed checks
  int         c_rdv, c_fd, c_start, fd_index;
  logic [7:0] rd_log[$];
  logic [3:0] idx_log[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc_n, act, exp);
    end
  endtask

  task automatic start_txn(input bit is_wr, input logic [7:0] a, input logic [7:0] d);
    m_active    = 1'b1;
    m_issued    = 1'b0;
    m_is_wr     = is_wr;
    e_bus_start = 1'b1;
    e_bus_rw    = is_wr;
    e_bus_addr  = a;
    e_bus_wdata = is_wr ? d : 8'h00;
  endtask

  task automatic model_step();
    bit req, tick, took;
    req = wr_req && !e_wr_ack;
    e_wr_ack = 0; e_wr_err = 0; e_bus_start = 0; e_rd_valid = 0; e_frame_done = 0; e_bus_err = 0;
    if (!reset) begin
      m_cnt = 0; m_idx = 0; m_wait = 0; m_pend = 0; m_active = 0; m_issued = 0;
      m_is_wr = 0; m_parked = 0;
      e_bus_rw = 0; e_bus_addr = 0; e_bus_wdata = 0; e_rd_data = 0; e_rd_index = 0; e_busy = 0;
      return;
    end
    tick  = (m_cnt == int'(TICKS) - 1);
    m_cnt = tick ? 0 : m_cnt + 1;
    took  = 1'b0;
    if (!m_active) begin
      if (req) start_txn(1'b1, wr_addr, wr_data);
      else if (m_pend && !hold) begin
        m_idx = 0; m_parked = 0; took = 1'b1;
        start_txn(1'b0, 8'(BASE + m_idx), 8'h00);
      end
    end else if (!m_issued) begin
      m_issued = 1'b1;
      m_wait   = 0;
    end else if (bus_done) begin
      m_active = 1'b0;
      if (m_is_wr) begin
        e_wr_ack = 1'b1;
        if (m_parked) begin
          m_parked = 1'b0;
          start_txn(1'b0, 8'(BASE + m_idx), 8'h00);
        end
      end else begin
        e_rd_valid = 1'b1;
        e_rd_data  = bus_rdata;
        e_rd_index = 4'(m_idx);
        if (m_idx == int'(NRD) - 1) e_frame_done = 1'b1;
        else if (!hold) begin
          m_idx++;
          if (req) begin
            m_parked = 1'b1;
            start_txn(1'b1, wr_addr, wr_data);
          end else start_txn(1'b0, 8'(BASE + m_idx), 8'h00);
        end
      end
    end else if (m_wait == int'(TMO) - 1) begin
      m_active  = 1'b0;
      m_parked  = 1'b0;
      e_bus_err = 1'b1;
      if (m_is_wr) begin
        e_wr_ack = 1'b1;
        e_wr_err = 1'b1;
      end
    end else m_wait++;
    m_pend = tick || (m_pend && !took);
    e_busy = m_active;
  endtask

  task automatic engine_drive();
    bus_done = 1'b0;
    if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        bus_done  = 1'b1;
        bus_rdata = eng_data;
      end
    end else if (spurious_en && $urandom_range(0, 29) == 0) begin
      bus_done  = 1'b1;
      bus_rdata = 8'($urandom);
    end
  endtask

  task automatic engine_observe();
    int d;
    if (bus_start === 1'b1) begin
      d        = eng_rand ? int'($urandom_range(1, 10)) : eng_delay;
      eng_data = eng_rand ? 8'($urandom) : bus_addr;
      eng_cnt  = (d > 0) ? d + 1 : 0;
    end
    if (drop_pending) begin
      wr_req       = 1'b0;
      drop_pending = 1'b0;
    end
    if (wr_ack === 1'b1) begin
      if (late_drop_en && $urandom_range(0, 1) == 1) drop_pending = 1'b1;
      else wr_req = 1'b0;
    end
  endtask

  task automatic cyc();
    engine_drive();
    model_step();
    @(posedge CLK);
    #1;
    check("wr_ack", 32'(wr_ack), 32'(e_wr_ack));
    check("wr_err", 32'(wr_err), 32'(e_wr_err));
    check("bus_start", 32'(bus_start), 32'(e_bus_start));
    check("bus_rw", 32'(bus_rw), 32'(e_bus_rw));
    check("bus_addr", 32'(bus_addr), 32'(e_bus_addr));
    check("bus_wdata", 32'(bus_wdata), 32'(e_bus_wdata));
    check("rd_valid", 32'(rd_valid), 32'(e_rd_valid));
    check("rd_index", 32'(rd_index), 32'(e_rd_index));
    check("rd_data", 32'(rd_data), 32'(e_rd_data));
    check("frame_done", 32'(frame_done), 32'(e_frame_done));
    check("bus_err", 32'(bus_err), 32'(e_bus_err));
    check("busy", 32'(busy), 32'(e_busy));
    if (rd_valid === 1'b1) begin
      c_rdv++;
      rd_log.push_back(rd_data);
      idx_log.push_back(rd_index);
    end
    if (frame_done === 1'b1) begin
      c_fd++;
      fd_index = int'(rd_index);
    end
    if (bus_start === 1'b1) c_start++;
    engine_observe();
    cyc_n++;
  endtask

  task automatic clear_ctr();
    c_rdv = 0; c_fd = 0; c_start = 0; fd_index = -1;
    rd_log.delete();
    idx_log.delete();
  endtask

  task automatic wait_start(input bit rw, input logic [7:0] a, input int limit, output int n);
    n = -1;
    for (int k = 1; k <= limit && n < 0; k++) begin
      cyc();
      if (bus_start === 1'b1 && bus_rw === rw && bus_addr === a) n = k;
    end
  endtask

  // which: 0 = wr_ack, 1 = bus_err, 2 = frame_done
  task automatic wait_flag(input int which, input int limit, output int n);
    logic v;
    n = -1;
    for (int k = 1; k <= limit && n < 0; k++) begin
      cyc();
      v = (which == 0) ? wr_ack : (which == 1) ? bus_err : frame_done;
      if (v === 1'b1) n = k;
    end
  endtask

  initial begin
    int n;
    int rst_left;
    logic [7:0] exp_rd[6];
    exp_rd = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26};
    reset = 1'b0; hold = 1'b0; wr_req = 1'b0; wr_addr = 8'h00; wr_data = 8'h00;
    bus_done = 1'b0; bus_rdata = 8'h00;
    clear_ctr();

    // Reset then first refresh tick
    repeat (3) cyc();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_start", 32'(bus_start), 32'd0);
    reset = 1'b1;
    wait_start(1'b0, 8'h21, 40, n);
    check("first_tick_latency", 32'(n), 32'd21);

    // Full refresh burst, engine echoes the address
    clear_ctr();
    wait_flag(2, 60, n);
    check("burst_reads", 32'(c_rdv), 32'd6);
    for (int i = 0; i < 6 && i < rd_log.size(); i++) begin
      check("burst_data", 32'(rd_log[i]), 32'(exp_rd[i]));
      check("burst_index", 32'(idx_log[i]), 32'(i));
    end
    check("frame_index", 32'(fd_index), 32'd5);

    // Single write, done 4 cycles after start
    eng_delay = 4;
    wr_req = 1'b1; wr_addr = 8'h22; wr_data = 8'h45;
    wait_start(1'b1, 8'h22, 10, n);
    check("wr_start_latency", 32'(n), 32'd1);
    check("wr_wdata", 32'(bus_wdata), 32'h45);
    clear_ctr();
    wait_flag(0, 20, n);
    check("wr_ack_latency", 32'(n), 32'd5);
    check("wr_single_start", 32'(c_start), 32'd0);

    // Write inserted between reads 2 and 3
    eng_delay = 2;
    wait_start(1'b0, 8'h23, 80, n);
    wr_req = 1'b1; wr_addr = 8'h30; wr_data = 8'h5A;
    clear_ctr();
    wait_start(1'b1, 8'h30, 10, n);
    check("ins_write_found", 32'(n > 0), 32'd1);
    check("ins_prior_reads", 32'(c_rdv), 32'd1);
    wait_start(1'b0, 8'h24, 20, n);
    check("resume_latency", 32'(n), 32'd3);
    wait_flag(2, 40, n);
    check("ins_total_reads", 32'(c_rdv), 32'd4);
    check("ins_frame_index", 32'(fd_index), 32'd5);

    // Hold suppresses bursts, release starts at once, mid-burst hold abandons
    hold = 1'b1;
    clear_ctr();
    repeat (45) cyc();
    check("hold_no_start", 32'(c_start), 32'd0);
    hold = 1'b0;
    cyc();
    check("hold_release_start", 32'(bus_start), 32'd1);
    check("hold_release_addr", 32'(bus_addr), 32'h21);
    wait_start(1'b0, 8'h23, 20, n);
    hold = 1'b1;
    clear_ctr();
    repeat (30) cyc();
    check("abandon_reads", 32'(c_rdv), 32'd1);
    check("abandon_no_frame", 32'(c_fd), 32'd0);
    check("abandon_no_start", 32'(c_start), 32'd0);

    // Watchdog on read, on write, and completion in the last allowed cycle
    eng_delay = 0;
    hold = 1'b0;
    wait_start(1'b0, 8'h21, 5, n);
    clear_ctr();
    wait_flag(1, 20, n);
    check("rd_timeout_latency", 32'(n), 32'd9);
    check("rd_timeout_no_valid", 32'(c_rdv), 32'd0);
    check("rd_timeout_idle", 32'(busy), 32'd0);
    hold = 1'b1;
    wr_req = 1'b1; wr_addr = 8'h40; wr_data = 8'h11;
    wait_start(1'b1, 8'h40, 5, n);
    check("wr_to_start", 32'(n), 32'd1);
    wait_flag(0, 20, n);
    check("wr_timeout_latency", 32'(n), 32'd9);
    check("wr_timeout_err", 32'(wr_err), 32'd1);
    check("wr_timeout_bus_err", 32'(bus_err), 32'd1);
    eng_delay = 8;
    wr_req = 1'b1; wr_addr = 8'h41; wr_data = 8'h12;
    wait_start(1'b1, 8'h41, 5, n);
    check("ack_cycle_req_ignored", 32'(n), 32'd2);
    wait_flag(0, 20, n);
    check("last_cycle_done_latency", 32'(n), 32'd9);
    check("last_cycle_no_err", 32'(wr_err), 32'd0);
    check("last_cycle_no_bus_err", 32'(bus_err), 32'd0);
    hold = 1'b0;

    // Random traffic
    eng_rand = 1'b1; spurious_en = 1'b1; late_drop_en = 1'b1;
    rst_left = 0;
    for (int it = 0; it < 6000; it++) begin
      if (rst_left > 0) begin
        rst_left--;
        if (rst_left == 0) reset = 1'b1;
      end else if ($urandom_range(0, 399) == 0) begin
        reset = 1'b0;
        rst_left = int'($urandom_range(1, 3));
      end
      if (hold && $urandom_range(0, 19) == 0) hold = 1'b0;
      else if (!hold && $urandom_range(0, 79) == 0) hold = 1'b1;
      if (!wr_req && $urandom_range(0, 19) == 0) begin
        wr_req = 1'b1;
        wr_addr = 8'($urandom);
        wr_data = 8'($urandom);
      end
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
